// File: rtl/node_pkg.sv
// Shared definitions for the node scheduler: FSM state codes, packet framing
// word counts and small helper functions.
// Optional build macro: NODE_SCHED_CHECKSUM_EN adds an XOR trailer word.
package node_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WAIT    = 3'd1;
    localparam state_t ST_REQ     = 3'd2;
    localparam state_t ST_CAP     = 3'd3;
    localparam state_t ST_TX_HDR  = 3'd4;
    localparam state_t ST_TX_DATA = 3'd5;
    localparam state_t ST_TX_SUM  = 3'd6;

    localparam int HDR_WORDS = 1;
`ifdef NODE_SCHED_CHECKSUM_EN
    localparam int TRL_WORDS = 1;
`else
    localparam int TRL_WORDS = 0;
`endif

    // Effective batch length: zero means one sample, anything above the
    // buffer depth is limited to a full buffer.
    function automatic int clamp_len(input int len, input int depth);
        if (len == 0)
            return 1;
        else if (len > depth)
            return depth;
        else
            return len;
    endfunction

    // Index of the lowest set mask bit at or above 'start'; 8 when none.
    function automatic int next_set_ch(input logic [7:0] mask, input int start);
        int r;
        r = 8;
        for (int i = 7; i >= 0; i--) begin
            if (i >= start && mask[i])
                r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/node_sample_buf.sv
// Circular sample buffer: synchronous write, combinational read, occupancy
// count 0..DEPTH. Writes into a full buffer and reads from an empty one are
// ignored so the pointers never pass each other.
module node_sample_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Status flags and qualified write/read strobes.
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_wr   = wr_en && !full;
        do_rd   = rd_en && !empty;
        rd_data = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_rd)
                count <= count + (AW+1)'(1);
            else if (do_rd && !do_wr)
                count <= count - (AW+1)'(1);
        end
    end

    // Sample storage; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/node_scheduler.sv
// Periodic multi-channel sampler that buffers samples and streams framed
// batches (sequence header + payload) over a valid/ready interface.
// Optional build macro: NODE_SCHED_CHECKSUM_EN appends an XOR trailer word.
module node_scheduler
    import node_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int PERIOD_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [PERIOD_W-1:0]        period,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [$clog2(DEPTH):0]     batch_len,
    input  logic [NUM_CH*DATA_W-1:0]   sensor_data,
    output logic [NUM_CH-1:0]          sensor_en,
    input  logic                       radio_busy,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       tx_last,
    output logic                       busy,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t              state;
    logic [PERIOD_W-1:0] per_cnt;
    logic                pending;
    logic [2:0]          ch;
    logic [DATA_W-1:0]   seq;
    logic [CW-1:0]       remain;
    logic [CW-1:0]       count;
    logic [CW-1:0]       eff_now;
    logic [7:0]          mask8;
    int                  first_ch;
    int                  nxt_ch;
    logic                tick;
    logic                tx_go;
    logic                hs;
    logic                wr_en;
    logic                rd_en;
    logic                ovf_evt;
    logic                buf_full;
    logic                buf_empty;
    logic [DATA_W-1:0]   cap_data;
    logic [DATA_W-1:0]   rd_data;
`ifdef NODE_SCHED_CHECKSUM_EN
    logic [DATA_W-1:0]   sum;
`endif

    node_sample_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (cap_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // Decisions for the current cycle: tick, transmit start, channel search.
    always_comb begin
        mask8    = 8'(ch_mask);
        first_ch = next_set_ch(mask8, 0);
        nxt_ch   = next_set_ch(mask8, int'(ch) + 1);
        eff_now  = CW'(clamp_len(int'(batch_len), DEPTH));
        tick     = (state != ST_IDLE) && (per_cnt == '0);
        tx_go    = (state == ST_WAIT) && enable && !radio_busy && (count >= eff_now);
        tx_valid = (state == ST_TX_HDR) || (state == ST_TX_DATA) || (state == ST_TX_SUM);
        hs       = tx_valid && tx_ready;
        wr_en    = (state == ST_CAP);
        ovf_evt  = (state == ST_CAP) && buf_full;
        rd_en    = (state == ST_TX_DATA) && hs && !buf_empty;
        cap_data = sensor_data[int'(ch)*DATA_W +: DATA_W];
        busy     = (state != ST_IDLE) && (state != ST_WAIT);
        sensor_en = (state == ST_REQ) ? (NUM_CH'(1) << ch) : '0;
    end

    // Stream word and end-of-packet marker, driven purely from state so they
    // hold steady while the consumer stalls.
    always_comb begin
        tx_data = '0;
        case (state)
            ST_TX_HDR:  tx_data = seq;
            ST_TX_DATA: tx_data = rd_data;
`ifdef NODE_SCHED_CHECKSUM_EN
            ST_TX_SUM:  tx_data = sum;
`endif
            default:    tx_data = '0;
        endcase
`ifdef NODE_SCHED_CHECKSUM_EN
        tx_last = (state == ST_TX_SUM);
`else
        tx_last = (state == ST_TX_DATA) && (remain == CW'(1));
`endif
    end

    // Sample-period down-counter: loaded while idle, ticks and reloads at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            per_cnt <= '0;
        else if (state == ST_IDLE || per_cnt == '0)
            per_cnt <= period;
        else
            per_cnt <= per_cnt - PERIOD_W'(1);
    end

    // Sticky overflow; a drop in the same cycle wins over the clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (ovf_evt)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    // Main sequencer: sampling rounds, pending tick, and packet framing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ch      <= '0;
            pending <= 1'b0;
            seq     <= '0;
            remain  <= '0;
`ifdef NODE_SCHED_CHECKSUM_EN
            sum     <= '0;
`endif
        end else begin
            if (tick && state != ST_WAIT)
                pending <= 1'b1;
            case (state)
                ST_IDLE: begin
                    pending <= 1'b0;
                    if (enable)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_go) begin
                        remain <= eff_now;
                        state  <= ST_TX_HDR;
                        if (tick)
                            pending <= 1'b1;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                    end else if (tick || pending) begin
                        pending <= 1'b0;
                        if (first_ch < 8) begin
                            ch    <= 3'(first_ch);
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    if (enable && nxt_ch < 8) begin
                        ch    <= 3'(nxt_ch);
                        state <= ST_REQ;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_TX_HDR: begin
                    if (hs) begin
`ifdef NODE_SCHED_CHECKSUM_EN
                        sum <= seq;
`endif
                        state <= ST_TX_DATA;
                    end
                end
                ST_TX_DATA: begin
                    if (hs) begin
`ifdef NODE_SCHED_CHECKSUM_EN
                        sum <= sum ^ rd_data;
`endif
                        remain <= remain - CW'(1);
                        if (remain == CW'(1)) begin
`ifdef NODE_SCHED_CHECKSUM_EN
                            state <= ST_TX_SUM;
`else
                            seq   <= seq + DATA_W'(1);
                            state <= enable ? ST_WAIT : ST_IDLE;
`endif
                        end
                    end
                end
`ifdef NODE_SCHED_CHECKSUM_EN
                ST_TX_SUM: begin
                    if (hs) begin
                        seq   <= seq + DATA_W'(1);
                        state <= enable ? ST_WAIT : ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_scheduler.sv
// Self-checking bench for node_scheduler. A queue-based model of the sample
// buffer and packet framing scores every streamed word; scenario tasks add
// targeted checks on timing, overflow, length clamping, enable and reset.
module tb_node_scheduler;

`ifdef NODE_SCHED_CHECKSUM_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] period;
    logic [3:0]  ch_mask;
    logic [4:0]  batch_len;
    logic [31:0] sensor_data;
    logic [3:0]  sensor_en;
    logic        radio_busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        overflow;
    logic        clr_ovf;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         en_cyc[$];
    logic [3:0] en_val[$];
    int         dropped;
    int         pkt_count;
    int         stall_err;
    logic [7:0] seq_m;
    int         word_idx;
    int         eff_m;
    int         cyc;
    logic [7:0] xsum;
    logic [3:0] prev_en;
    logic       prev_v, prev_r, prev_l;
    logic [7:0] prev_d;
    bit         rand_data, rand_ready;

    node_scheduler #(
        .NUM_CH(4), .DATA_W(8), .DEPTH(16), .PERIOD_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period),
        .ch_mask(ch_mask), .batch_len(batch_len), .sensor_data(sensor_data),
        .sensor_en(sensor_en), .radio_busy(radio_busy), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic int clamp_ref(input int b);
        if (b == 0) return 1;
        if (b > 16) return 16;
        return b;
    endfunction

    // Observe the DUT mid-cycle: capture samples into the model queue, log
    // sample requests, watch stall stability and score every stream word.
    always @(negedge clk) begin
        logic [7:0] samp;
        logic [7:0] exp_w;
        logic       exp_l;
        if (rst) begin
            prev_en = '0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; prev_l = 1'b0;
            word_idx = 0; cyc = 0;
        end else begin
            cyc++;
            if (prev_en != '0) begin
                samp = '0;
                for (int i = 0; i < 4; i++)
                    if (prev_en[i]) samp = sensor_data[i*8 +: 8];
                if (exp_q.size() < 16) exp_q.push_back(samp);
                else dropped++;
            end
            if (sensor_en != '0) begin
                en_cyc.push_back(cyc);
                en_val.push_back(sensor_en);
            end
            if (prev_v && !prev_r && (!tx_valid || tx_data !== prev_d || tx_last !== prev_l))
                stall_err++;
            if (tx_valid && tx_ready) begin
                obs_q.push_back({tx_last, tx_data});
                if (word_idx == 0) begin
                    eff_m = clamp_ref(int'(batch_len));
                    exp_w = seq_m;
                    xsum  = seq_m;
                end else if (word_idx <= eff_m) begin
                    if (exp_q.size() == 0) exp_w = 'x;
                    else exp_w = exp_q.pop_front();
                    xsum = xsum ^ exp_w;
                end else begin
                    exp_w = xsum;
                end
                exp_l = (word_idx == eff_m + TRL);
                compared++;
                if (tx_data !== exp_w || tx_last !== exp_l) begin
                    mismatched++;
                    $display("[TB] FAIL stream_word idx=%0d pkt=%0d: got data=%02h last=%b, want data=%02h last=%b",
                             word_idx, pkt_count, tx_data, tx_last, exp_w, exp_l);
                end
                if (exp_l) begin
                    word_idx = 0;
                    seq_m = seq_m + 8'd1;
                    pkt_count++;
                end else begin
                    word_idx++;
                end
            end
            prev_en = sensor_en; prev_v = tx_valid; prev_r = tx_ready;
            prev_d = tx_data; prev_l = tx_last;
        end
    end

    // Advance one clock and refresh any randomized inputs.
    task automatic tick_cycle();
        @(posedge clk);
        #2;
        if (rand_data)  sensor_data = $urandom;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; ch_mask = '0; period = '0; batch_len = '0;
        radio_busy = 1'b0; tx_ready = 1'b0; clr_ovf = 1'b0; sensor_data = '0;
        rand_data = 1'b0; rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete(); obs_q.delete(); en_cyc.delete(); en_val.delete();
        dropped = 0; pkt_count = 0; stall_err = 0; seq_m = '0;
        #2 rst = 1'b0;
    endtask

    task automatic wait_pkts(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (pkt_count < n && k < budget) begin
            tick_cycle();
            k++;
        end
        compared++;
        if (pkt_count < n) begin
            mismatched++;
            $display("[TB] FAIL %s timeout: got %0d packets, want %0d", name, pkt_count, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; ch_mask = 4'hF; period = 16'd3; batch_len = 5'd1;
        radio_busy = 1'b0; tx_ready = 1'b1; clr_ovf = 1'b0; sensor_data = 32'hA5A5A5A5;
        rand_data = 1'b0; rand_ready = 1'b0;
        #3;
        compared++;
        if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_stream: got valid=%b last=%b data=%02h, want 0 0 00", tx_valid, tx_last, tx_data);
        end
        compared++;
        if (sensor_en !== 4'h0 || busy !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got sensor_en=%b busy=%b ovf=%b, want 0000 0 0", sensor_en, busy, overflow);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        ch_mask = 4'b0101; period = 16'd9; batch_len = 5'd4; tx_ready = 1'b1;
        sensor_data = 32'h0022_0011;
        enable = 1'b1;
        wait_pkts(2, 400, "basic_pkts");
        compared++;
        if (en_val.size() < 3 || en_val[0] !== 4'b0001 || en_val[1] !== 4'b0100 || en_val[2] !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL basic_sensor_en order: got %0d pulses, want 0001,0100,0001", en_val.size());
        end
        compared++;
        if (en_cyc.size() < 3 || en_cyc[1] - en_cyc[0] != 2 || en_cyc[2] - en_cyc[0] != 10) begin
            mismatched++;
            $display("[TB] FAIL basic_sensor_en spacing: want 2 and 10 cycle offsets");
        end
        begin
            logic [7:0] want [5];
            want[0] = 8'h00; want[1] = 8'h11; want[2] = 8'h22; want[3] = 8'h11; want[4] = 8'h22;
            for (int i = 0; i < 5; i++) begin
                compared++;
                if (obs_q.size() <= i || obs_q[i][7:0] !== want[i] || obs_q[i][8] !== (i == 4 + TRL)) begin
                    mismatched++;
                    $display("[TB] FAIL basic_word%0d: got %03h, want data=%02h", i,
                             (obs_q.size() > i) ? obs_q[i] : 9'h1FF, want[i]);
                end
            end
        end
        compared++;
        if (obs_q.size() < 6 + 2*TRL || obs_q[5 + TRL][7:0] !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL basic_second_header: want 01");
        end
        enable = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        ch_mask = 4'($urandom_range(1, 15)); period = 16'($urandom_range(2, 8));
        batch_len = 5'($urandom_range(1, 6));
        rand_data = 1'b1; rand_ready = 1'b1;
        enable = 1'b1;
        wait_pkts(4, 3000, "stall_pkts");
        compared++;
        if (stall_err != 0) begin
            mismatched++;
            $display("[TB] FAIL stall_stability: got %0d unstable stalls, want 0", stall_err);
        end
        rand_ready = 1'b0; enable = 1'b0;
    endtask

    task automatic test_overflow();
        int k;
        int d0;
        logic [7:0] first_samp;
        do_reset();
        ch_mask = 4'b0001; period = 16'd3; batch_len = 5'd4; radio_busy = 1'b1;
        tx_ready = 1'b1; rand_data = 1'b1; enable = 1'b1;
        k = 0;
        while (exp_q.size() < 16 && k < 200) begin tick_cycle(); k++; end
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_at_16: got %b, want 0", overflow);
        end
        k = 0;
        while (dropped < 1 && k < 40) begin tick_cycle(); k++; end
        compared++;
        if (overflow !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovf_at_17: got %b, want 1", overflow);
        end
        ch_mask = 4'b0000;
        repeat (6) tick_cycle();
        clr_ovf = 1'b1;
        tick_cycle();
        clr_ovf = 1'b0;
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_clear: got %b, want 0", overflow);
        end
        clr_ovf = 1'b1; ch_mask = 4'b0001;
        d0 = dropped;
        k = 0;
        while (dropped == d0 && k < 40) begin tick_cycle(); k++; end
        compared++;
        if (overflow !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovf_priority: got %b, want 1", overflow);
        end
        tick_cycle();
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_clear_after: got %b, want 0", overflow);
        end
        clr_ovf = 1'b0; ch_mask = 4'b0000;
        repeat (6) tick_cycle();
        first_samp = exp_q[0];
        radio_busy = 1'b0;
        wait_pkts(4, 300, "ovf_drain");
        compared++;
        if (obs_q.size() < 2 || obs_q[1][7:0] !== first_samp) begin
            mismatched++;
            $display("[TB] FAIL ovf_oldest_first: want %02h as first payload", first_samp);
        end
        enable = 1'b0;
    endtask

    task automatic test_batch_len();
        int len;
        int np;
        do_reset();
        ch_mask = 4'b0011; period = 16'd7; batch_len = 5'd0; tx_ready = 1'b1;
        rand_data = 1'b1; enable = 1'b1;
        wait_pkts(3, 300, "len0_pkts");
        len = 0; np = 0;
        foreach (obs_q[i]) begin
            len++;
            if (obs_q[i][8] && np < 3) begin
                compared++;
                if (len != 2 + TRL) begin
                    mismatched++;
                    $display("[TB] FAIL len0_packet%0d: got %0d words, want %0d", np, len, 2 + TRL);
                end
                np++;
                len = 0;
            end
        end
        do_reset();
        ch_mask = 4'b1111; period = 16'd9; batch_len = 5'd31; tx_ready = 1'b1;
        rand_data = 1'b1; enable = 1'b1;
        wait_pkts(1, 400, "len31_pkts");
        len = 0;
        foreach (obs_q[i]) if (len == 0 && obs_q[i][8]) len = i + 1;
        compared++;
        if (len != 17 + TRL) begin
            mismatched++;
            $display("[TB] FAIL len31_packet: got %0d words, want %0d", len, 17 + TRL);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int k;
        int n_en;
        do_reset();
        ch_mask = 4'b0001; period = 16'd2; batch_len = 5'd3;
        rand_data = 1'b1; rand_ready = 1'b1; enable = 1'b1;
        k = 0;
        while (obs_q.size() == 0 && k < 300) begin tick_cycle(); k++; end
        enable = 1'b0; batch_len = 5'd6;
        k = 0;
        while (busy && k < 300) begin tick_cycle(); k++; end
        compared++;
        if (pkt_count != 1 || obs_q.size() == 0 || obs_q[obs_q.size()-1][8] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL endrop_complete: got %0d packets, want 1 finished", pkt_count);
        end
        n_en = en_val.size();
        repeat (40) tick_cycle();
        compared++;
        if (en_val.size() != n_en || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL endrop_quiet: got %0d new pulses busy=%b, want 0 and 0", en_val.size() - n_en, busy);
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        ch_mask = 4'b0011; period = 16'd3; batch_len = 5'd4; tx_ready = 1'b0;
        rand_data = 1'b1; enable = 1'b1;
        k = 0;
        while (!tx_valid && k < 200) begin tick_cycle(); k++; end
        rst = 1'b1;
        #1;
        compared++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_immediate: got valid=%b busy=%b, want 0 0", tx_valid, busy);
        end
        repeat (2) @(posedge clk);
        exp_q.delete(); obs_q.delete(); pkt_count = 0; seq_m = '0;
        #2 rst = 1'b0;
        ch_mask = 4'b0000; batch_len = 5'd1; tx_ready = 1'b1; enable = 1'b1;
        repeat (40) tick_cycle();
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_count: got %0d streamed words, want 0", obs_q.size());
        end
        enable = 1'b0;
    endtask

    task automatic test_checksum();
        logic [7:0] want [4];
        do_reset();
        want[0] = 8'h00; want[1] = 8'h11; want[2] = 8'h22; want[3] = 8'h33;
        ch_mask = 4'b0101; period = 16'd9; batch_len = 5'd2; tx_ready = 1'b1;
        sensor_data = 32'h0022_0011; enable = 1'b1;
        wait_pkts(1, 200, "sum_pkts");
        for (int i = 0; i < 3 + TRL; i++) begin
            compared++;
            if (obs_q.size() <= i || obs_q[i][7:0] !== want[i] || obs_q[i][8] !== (i == 2 + TRL)) begin
                mismatched++;
                $display("[TB] FAIL sum_word%0d: got %03h, want data=%02h", i,
                         (obs_q.size() > i) ? obs_q[i] : 9'h1FF, want[i]);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        $display("[TB] node_scheduler bench start (trailer words=%0d)", TRL);
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_batch_len();
        test_enable_drop();
        test_reset_mid();
        test_checksum();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/node_scheduler.md
Name: node_scheduler

Overview:
- Parametrised successor to the single-sensor node controller path: schedules periodic sampling of NUM_CH sensor channels and buffers the samples in an internal circular buffer.
- When a programmable batch is ready and the radio is idle, streams a framed batch (sequence header + payload) over a valid/ready interface to the packetiser/radio.
- Sits between the sensor array and the packetiser inside the node top level.

Parameters:
- NUM_CH, 4, number of sensor channels (1..8)
- DATA_W, 8, sample and stream word width
- DEPTH, 16, sample buffer entries (power of 2, ≥2)
- PERIOD_W, 16, width of sample-period counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  global enable
- period  in  PERIOD_W  sample interval; a tick occurs every period+1 cycles
- ch_mask  in  NUM_CH  channel enable bits; bit i enables channel i
- batch_len  in  $clog2(DEPTH)+1  samples per packet
- sensor_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- sensor_en  out  NUM_CH  one-hot, one-cycle sample request
- radio_busy  in  1  radio occupied; no batch starts while high
- tx_data  out  DATA_W  stream word
- tx_valid  out  1  stream word valid
- tx_ready  in  1  downstream accepts
- tx_last  out  1  final word of packet
- busy  out  1  high in any state except IDLE/WAIT
- overflow  out  1  sticky: a sample was dropped
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset: all outputs 0; FSM IDLE; buffer pointers, count, seq counter, period counter 0; pending tick cleared.
- FSM states: IDLE, WAIT, REQ, CAP, TX_HDR, TX_DATA (TX_SUM with the optional feature).
- IDLE -> WAIT when enable=1. The period counter loads period and decrements in every non-IDLE state. At 0 it ticks and reloads.
- WAIT: on tick (or pending tick), go to REQ with ch = lowest set bit of ch_mask. If ch_mask=0, the tick is consumed and no sampling occurs.
- REQ: sensor_en[ch]=1 for one cycle, then go to CAP.
- CAP: capture the ch slice of sensor_data and write it at wr_ptr.
  - If count==DEPTH: drop the sample, set overflow, leave pointers unchanged.
  - Advance to the next set mask bit: go to REQ if one remains, otherwise go to CHECK logic.
  - A round costs 2 cycles per enabled channel.
- CHECK (combinational, in WAIT):
  - Condition: count ≥ eff_len and radio_busy=0 and enable=1.
  - If true, enter TX_HDR. TX takes priority over a tick arriving in the same cycle; that tick becomes pending.
  - eff_len = 1 if batch_len=0; DEPTH if batch_len > DEPTH; otherwise batch_len.
- Ticks outside WAIT set a single pending flag. Multiple ticks collapse into one. Pending is served on return to WAIT.
- TX_HDR: tx_data = seq (DATA_W bits, wraps), tx_valid=1. On handshake, go to TX_DATA.
- TX_DATA: emit eff_len words from rd_ptr, incrementing rd_ptr and decrementing count on each handshake.
  - tx_last is asserted on the final payload word.
  - After the last handshake: seq increments (mod 2^DATA_W), then return to WAIT.
- Handshake rules:
  - tx_data and tx_last remain stable while tx_valid && !tx_ready.
  - tx_valid never drops without a handshake.
  - First header word is valid on the cycle after the TX decision (1-cycle latency).
- eff_len is latched at TX start. Changes to batch_len mid-packet have no effect.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
- enable deassert:
  - Sampling stops after the current CAP.
  - An active packet completes fully, then the FSM goes to IDLE.
  - Buffer contents are retained.
- clr_ovf has priority below a simultaneous overflow event: overflow stays set.
- Async rst mid-packet: tx_valid drops immediately and buffer contents are discarded (count=0).

Optional Feature:
- Macro: NODE_SCHED_CHECKSUM_EN.
- With the macro: after the final payload word, TX_SUM emits a trailer = XOR of the header and all payload words. tx_last moves to the trailer. Packet length is eff_len+2.
- Without the macro: no TX_SUM state; packet length is eff_len+1.

Decomposition:
- Package node_pkg holds:
  - FSM state enum
  - header/trailer word counts
  - clamp function for eff_len
  - next-set-bit channel function
- One sub-module: node_sample_buf (circular buffer with wr/rd pointers, count, full/empty; synchronous write, combinational read).

Test Plan:
- NUM_CH=4, ch_mask=4'b0101, period=9, batch_len=4, tx_ready=1, sensor ch0=0x11, ch2=0x22:
  - sensor_en pulses 0001 then 0100 every 10 cycles.
  - After two rounds, packet 0x00,0x11,0x22,0x11,0x22 is emitted with tx_last on the 5th word.
  - Second packet header = 0x01.
- tx_ready toggled 1-0-0-1 randomly during a packet -> tx_data/tx_last stable during stalls; no word lost or duplicated.
- radio_busy=1 held with batch_len=4 and DEPTH=16 -> count saturates at 16, overflow=1 on the 17th sample. clr_ovf clears it. Releasing busy sends the oldest 4 samples first.
- batch_len=0 -> 1-sample packets. batch_len=31 -> 16-sample packets.
- enable dropped mid-packet -> packet completes, busy falls, no further sensor_en. rst asserted mid-packet -> tx_valid=0 that same cycle, count=0.
- With NODE_SCHED_CHECKSUM_EN, payload 0x11,0x22 and seq 0x00 -> trailer 0x33 carries tx_last.
